// File: rtl/div_rcp_seq.sv
// Purpose: sequential s1.31 reciprocal via a 1024-entry divide ROM indexed by the normalised operand.
// Latency: result strobe in the 5th cycle after the accepting edge; one result per 5 cycles at best.
// Backpressure: req_ready high only in IDLE/DONE; rsp_valid is a strobe with no backpressure.
//
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   req_valid/req_data  - 32-bit two's-complement operand, accepted when req_ready && !kill
//   req_ready           - block can take a request this cycle
//   kill                - abort the operation in flight (also blocks acceptance)
//   rom_a / rom_out     - registered ROM address; ROM returns data one cycle after it samples rom_a
//   rsp_valid/rsp_data  - one-cycle strobe with the s1.31 result; rsp_data holds between strobes
module div_rcp_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_data,
    output logic        req_ready,
    input  logic        kill,
    output logic [9:0]  rom_a,
    input  logic [15:0] rom_out,
    output logic        rsp_valid,
    output logic [31:0] rsp_data
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ABS  = 3'd1,
        NORM = 3'd2,
        LOOK = 3'd3,
        CAPT = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic        accept;

    logic [31:0] x_q;
    logic        sign_q;
    logic [31:0] abs_q;
    logic [4:0]  lz_q;

    logic [4:0]  lz_c;
    logic [9:0]  rom_a_c;
    logic [31:0] mant_c;
    logic [31:0] r_c;
    logic [31:0] res_c;

    // Leading-zero count; an all-zero operand reports 0 and is special-cased later.
    function automatic logic [4:0] lzc32(input logic [31:0] v);
        lzc32 = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) lzc32 = 5'(31 - i);
        end
    endfunction

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid && !kill;
                if (accept) state_nxt = ABS;
            end
            ABS:  state_nxt = kill ? IDLE : NORM;
            NORM: state_nxt = kill ? IDLE : LOOK;
            LOOK: state_nxt = kill ? IDLE : CAPT;
            CAPT: state_nxt = kill ? IDLE : DONE;
            DONE: begin
                req_ready = 1'b1;
                rsp_valid = 1'b1;
                accept    = req_valid && !kill;
                state_nxt = accept ? ABS : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    assign lz_c = lzc32(abs_q);
    // Normalised operand bits [30:21]: the leading one is implicit, so the
    // next ten bits index the ROM. Truncation drops bit 31.
    assign rom_a_c = 10'((abs_q << lz_c) >> 21);

    // ROM word is the fraction below the implicit 0.5 of the s1.31 mantissa;
    // shifting right by (31 - lz) rescales by the operand's exponent.
    assign mant_c = {1'b0, 1'b1, rom_out, 14'b0};
    assign r_c    = mant_c >> (5'd31 - lz_q);
    // Negative results use one's complement, which keeps -0 distinct from +0
    // and matches the expected rounding for this reciprocal format.
    assign res_c  = (abs_q == 32'd0) ? 32'h7FFF_FFFF : (sign_q ? ~r_c : r_c);

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q      <= 32'd0;
            sign_q   <= 1'b0;
            abs_q    <= 32'd0;
            lz_q     <= 5'd0;
            rom_a    <= 10'd0;
            rsp_data <= 32'd0;
        end else begin
            if (accept) begin
                x_q    <= req_data;
                sign_q <= req_data[31];
            end
            // 0x80000000 negates to itself, which is the correct magnitude.
            if (state == ABS && !kill) abs_q <= sign_q ? (~x_q + 32'd1) : x_q;
            if (state == NORM && !kill) begin
                lz_q  <= lz_c;
                rom_a <= rom_a_c;
            end
            if (state == CAPT && !kill) rsp_data <= res_c;
        end
    end

endmodule

// File: tb/tb_div_rcp_seq.sv
module tb_div_rcp_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_data;
    logic        req_ready;
    logic        kill;
    logic [9:0]  rom_a;
    logic [15:0] rom_out = 16'd0;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_rsp = 32'd0;

    always #5 clk = ~clk;

    // ROM stub: registers the address, returns {addr, 6'b0} next cycle.
    always @(posedge clk) rom_out <= {rom_a, 6'b0};

    div_rcp_seq dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .kill      (kill),
        .rom_a     (rom_a),
        .rom_out   (rom_out),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic longint m_abs(input logic [31:0] x);
        longint v;
        v = longint'({32'd0, x});
        if (x[31]) return 64'h1_0000_0000 - v;
        return v;
    endfunction

    function automatic int m_lz(input longint a);
        if (a == 0) return 0;
        return 32 - $clog2(a + 1);
    endfunction

    function automatic logic [9:0] m_rom_a(input logic [31:0] x);
        longint a;
        longint n;
        a = m_abs(x);
        n = (a << m_lz(a)) & 64'hFFFF_FFFF;
        return 10'((n >> 21) & 64'h3FF);
    endfunction

    function automatic logic [31:0] m_rsp(input logic [31:0] x);
        longint      a;
        longint      rom;
        longint      mant;
        int          lz;
        logic [31:0] r;
        a = m_abs(x);
        if (a == 0) return 32'h7FFF_FFFF;
        lz   = m_lz(a);
        rom  = longint'({54'd0, m_rom_a(x)}) * 64;
        mant = 64'h4000_0000 + rom * 16384;
        r    = 32'(mant >> (31 - lz));
        return x[31] ? ~r : r;
    endfunction

    function automatic logic [31:0] gen_x();
        logic [31:0] corner [5];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'h7FFF_FFFF;
        corner[4] = 32'hFFFF_FFFF;
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 40));
            2:       return 32'd0 - 32'($urandom_range(1, 40));
            default: return corner[$urandom_range(0, 4)];
        endcase
    endfunction

    // Runs one operation starting at a negedge with the block ready.
    // kill_at / rst_at: cycle after accept (1=ABS .. 5=DONE) to abort, 0 = never.
    // chain: present nx from accept+1 so it is taken in DONE.
    task automatic run_op(input logic [31:0] x, input logic [9:0] exp_a, input logic [31:0] exp_r,
                          input int kill_at, input int rst_at, input bit chain, input logic [31:0] nx);
        req_valid = 1'b1;
        req_data  = x;
        kill      = 1'b0;
        chk("accept_ready", {31'd0, req_ready}, 32'd1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = chain;
                req_data  = chain ? nx : 32'hDEAD_BEEF;
            end
            if (c < 5) begin
                chk("busy_ready", {31'd0, req_ready}, 32'd0);
                chk("busy_valid", {31'd0, rsp_valid}, 32'd0);
            end
            if (c == 3) chk("rom_a_look", {22'd0, rom_a}, {22'd0, exp_a});
            if (c == 5) begin
                chk("done_valid", {31'd0, rsp_valid}, 32'd1);
                chk("done_data", rsp_data, exp_r);
                chk("done_ready", {31'd0, req_ready}, 32'd1);
                last_rsp = exp_r;
            end
            if (c == kill_at) begin
                kill = 1'b1;
                if (c == 5) req_valid = 1'b1;
                @(negedge clk);
                kill      = 1'b0;
                req_valid = 1'b0;
                chk("kill_ready", {31'd0, req_ready}, 32'd1);
                chk("kill_valid", {31'd0, rsp_valid}, 32'd0);
                chk("kill_data", rsp_data, last_rsp);
                return;
            end
            if (c == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                chk("rst_rom_a", {22'd0, rom_a}, 32'd0);
                chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
                chk("rst_data", rsp_data, 32'd0);
                last_rsp  = 32'd0;
                reset     = 1'b0;
                req_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_valid", {31'd0, rsp_valid}, 32'd0);
            chk("idle_ready", {31'd0, req_ready}, 32'd1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] x;
        logic [31:0] nx;
        bit          ch;
        int          ka;

        reset     = 1'b1;
        req_valid = 1'b1;
        req_data  = 32'h0000_0003;
        kill      = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_data", rsp_data, 32'd0);
        chk("reset_rom_a", {22'd0, rom_a}, 32'd0);
        reset     = 1'b0;
        req_valid = 1'b0;
        idle(1);

        // Directed vectors
        run_op(32'h0000_0001, 10'h000, 32'h4000_0000, 0, 0, 1'b0, 32'd0);
        idle(1);
        run_op(32'h0000_0003, 10'h200, 32'h3000_0000, 0, 0, 1'b1, 32'h0000_0002);
        run_op(32'h0000_0002, 10'h000, 32'h2000_0000, 0, 0, 1'b0, 32'd0);
        idle(2);
        run_op(32'hFFFF_FFFF, 10'h000, 32'hBFFF_FFFF, 0, 0, 1'b0, 32'd0);
        idle(1);
        run_op(32'h0000_0000, 10'h000, 32'h7FFF_FFFF, 0, 0, 1'b0, 32'd0);
        idle(1);
        run_op(32'h8000_0000, 10'h000, 32'hFFFF_FFFF, 0, 0, 1'b0, 32'd0);
        idle(1);

        // Kill in LOOK, then a clean request
        run_op(32'h0000_0003, 10'h200, 32'h3000_0000, 3, 0, 1'b0, 32'd0);
        idle(4);
        run_op(32'h0000_0001, 10'h000, 32'h4000_0000, 0, 0, 1'b0, 32'd0);
        idle(1);

        // Kill in the other busy states and in DONE
        for (int k = 1; k <= 5; k++) begin
            x = gen_x();
            run_op(x, m_rom_a(x), m_rsp(x), k, 0, 1'b0, 32'd0);
            idle(2);
        end

        // Kill in IDLE blocks acceptance
        kill      = 1'b1;
        req_valid = 1'b1;
        req_data  = 32'h0000_0005;
        @(negedge clk);
        chk("idle_kill_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_kill_valid", {31'd0, rsp_valid}, 32'd0);
        kill = 1'b0;
        idle(1);

        // Reset in CAPT, then request accepted right after deassertion
        run_op(32'h0000_0003, 10'h200, 32'h3000_0000, 0, 4, 1'b0, 32'd0);
        run_op(32'h0000_0003, 10'h200, 32'h3000_0000, 0, 0, 1'b0, 32'd0);
        idle(1);

        // Randomised traffic against the model
        x = gen_x();
        for (int i = 0; i < 60; i++) begin
            nx = gen_x();
            ch = (i < 59) && ($urandom_range(0, 2) == 0);
            ka = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 5)) : 0;
            if (ka != 0) ch = 1'b0;
            run_op(x, m_rom_a(x), m_rsp(x), ka, 0, ch, nx);
            if (!ch) idle(int'($urandom_range(0, 2)));
            x = nx;
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
